// File: rtl/student_bus_arbiter8_pkg.sv
// Shared constants and FSM encoding for the eight-way round-robin bus arbiter.
package student_bus_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int BUS_W   = 16;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/student_bus_arbiter8_rr_pick.sv
// Rotating priority search: first set bit of req at or after start, wrapping 7 -> 0.
import student_bus_arbiter8_pkg::*;

module student_rr_pick8 (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = start + IDX_W'(i);
      if (req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/student_mux8way16.sv
// Eight-way 16-bit combinational mux; sel = 0 picks a ... sel = 7 picks h.
module student_mux8way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/student_bus_arbiter8.sv
// Round-robin owner of a shared 16-bit bus with a hold limit under contention.
import student_bus_arbiter8_pkg::*;

module student_bus_arbiter8 #(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [BUS_W-1:0]     a,
  input  logic [BUS_W-1:0]     b,
  input  logic [BUS_W-1:0]     c,
  input  logic [BUS_W-1:0]     d,
  input  logic [BUS_W-1:0]     e,
  input  logic [BUS_W-1:0]     f,
  input  logic [BUS_W-1:0]     g,
  input  logic [BUS_W-1:0]     h,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid,
  output logic [BUS_W-1:0]     bus_out,
  output logic                 bus_valid
);

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [NUM_REQ-1:0] cand;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               issue, go_idle;
  logic [BUS_W-1:0]   mux_out;

  // ptr always equals owner+1 while granted, so one picker serves both the
  // idle scan and the handoff scan; masking the owner leaves only contenders.
  assign cand = req & ~gnt;

  student_rr_pick8 u_pick (
    .req   (cand),
    .start (ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  student_mux8way16 u_mux (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .e   (e),
    .f   (f),
    .g   (g),
    .h   (h),
    .sel (gnt_idx),
    .out (mux_out)
  );

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    go_idle = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          issue   = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!req[gnt_idx]) begin
          if (pick_any) begin
            issue = 1'b1;
          end else begin
            go_idle = 1'b1;
            state_n = IDLE;
          end
        end else if (hold_cnt == CNT_W'(HOLD_MAX) && pick_any) begin
          issue = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      bus_out   <= '0;
      bus_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (issue) begin
        gnt       <= NUM_REQ'(1) << pick_idx;
        gnt_idx   <= pick_idx;
        gnt_valid <= 1'b1;
        ptr       <= pick_idx + IDX_W'(1);
        hold_cnt  <= CNT_W'(1);
      end else if (go_idle) begin
        gnt       <= '0;
        gnt_idx   <= '0;
        gnt_valid <= 1'b0;
        hold_cnt  <= '0;
      end else if (state == GRANT && hold_cnt != CNT_W'(HOLD_MAX)) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
      bus_out   <= gnt_valid ? mux_out : '0;
      bus_valid <= gnt_valid;
    end
  end

endmodule

// File: doc/student_bus_arbiter8.md
Name: student_bus_arbiter8

Overview:
Round-robin arbiter that shares one 16-bit bus among eight requesters.
- Grants ownership to one requester at a time.
- Steers the owner's data onto a registered bus output through the existing 8-way 16-bit mux (student_mux8way16).
- Limits how long one owner may hold the bus while others wait.
- Sits between the requesters and any shared downstream consumer, such as a register or memory write port.

Parameters:
HOLD_MAX, 4, maximum consecutive grant cycles before forced rotation when others are waiting; legal range 1..7.
CNT_W, 3, width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req  input  8  request vector; req[i] is held high while requester i wants or holds the bus.
a, b, c, d, e, f, g, h  input  16 each  requester data; a = requester 0 ... h = requester 7.
gnt  output  8  one-hot grant, registered; 0 when idle.
gnt_idx  output  3  binary index of the owner, registered; 0 when idle.
gnt_valid  output  1  high while a grant is held.
bus_out  output  16  registered copy of the owner's data.
bus_valid  output  1  bus_out holds valid data.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, gnt_idx=0, gnt_valid=0, bus_out=0, bus_valid=0.
  - Internal state: ptr=0, hold_cnt=0, state=IDLE.
  - Outputs clear immediately, without waiting for a clock edge.
  - Reset mid-grant aborts the grant; no handoff occurs.
- Scan: "first set bit of req at or after position p, modulo 8." Bit 7 wraps to bit 0.
- Whenever a grant is issued: ptr <= new_owner+1 (mod 8), hold_cnt <= 1.
- State IDLE (gnt_valid=0):
  - req != 0: owner = scan from ptr; go to GRANT.
  - Otherwise: stay in IDLE.
- State GRANT (owner o):
  - Release: req[o]=0.
    - If any other req bit is set: hand off to scan from o+1 on the same edge (no idle bubble).
    - Otherwise: go to IDLE, with gnt=0, gnt_idx=0, gnt_valid=0.
  - Preempt: req[o]=1, hold_cnt==HOLD_MAX, and another req bit is set → hand off to scan from o+1.
  - Otherwise: hold the grant.
    - hold_cnt increments and saturates at HOLD_MAX.
    - With no contention, the owner keeps the bus indefinitely.
- Grant latency: one edge from the req change to the gnt change. gnt, gnt_idx and gnt_valid are always mutually consistent.
- Data path:
  - Every edge: bus_out <= gnt_valid ? mux8way16(a..h, gnt_idx) : 0.
  - Every edge: bus_valid <= gnt_valid.
  - Data is sampled in the cycle the grant is visible and appears one cycle later.
- Requesters wiggling req without holding a grant have no effect until scanned.
- Requesters that are not granted receive no acknowledgement; they keep req high until gnt shows them.
- HOLD_MAX=1 gives per-cycle rotation under contention.

Decomposition:
- Shared package/include: IDLE/GRANT state encodings, NUM_REQ=8, BUS_W=16.
- The scan logic (priority search from a rotating start) is one natural sub-module: student_rr_pick8. Inputs: req[7:0], start[2:0]. Outputs: idx[2:0], any.
- The data mux reuses student_mux8way16 unchanged.

Test Plan:
1. Reset, then req=8'h04 with c=16'hBEEF → after edge 1: gnt=8'h04, gnt_idx=2, gnt_valid=1; after edge 2: bus_out=16'hBEEF, bus_valid=1.
2. From reset, req=8'hFF held, HOLD_MAX=4 → owners 0,1,2,...,7,0 in order, each for exactly 4 cycles.
3. Owner 3 drops req[3] while req[1] and req[6] are set → next edge gnt=8'h40 (idx 6), gnt_valid never drops.
4. Owner 7 releases with req=8'h01 → gnt=8'h01 (wrap). Owner 0 then releases with req=0 → gnt=0, gnt_valid=0; next edge bus_valid=0, bus_out=0.
5. Sole requester 5 holds req for 20 cycles → gnt stays 8'h20 throughout; hold_cnt saturates at 4 without rotation.
6. rst_n pulled low mid-cycle while owner 2 is granted → all outputs 0 before the next edge. After rst_n rises with req=8'h84 → first grant goes to idx 2 (scan from ptr=0).
